// File: rtl/fifo_rd_stream.sv
`default_nettype none
//============================================================================
// Module      : fifo_rd_stream
// Description : Read-side adapter for a synchronous FIFO with one cycle of
//               read latency. It issues the FIFO read strobe and captures the
//               returned word in the following cycle. The word is presented
//               on a valid/ready stream through a 2-entry skid buffer, which
//               sustains one beat per cycle. It flags FIFO underflow (sticky)
//               and counts delivered beats.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               fifo_empty         - FIFO empty flag
//               fifo_underflow     - FIFO underflow flag (cycle after a read)
//               fifo_data_out      - FIFO read data (cycle after rd_en)
//               fifo_rd_en         - FIFO read strobe (combinational)
//               m_valid / m_ready  - stream handshake
//               m_data             - stream data (buffer head)
//               rd_count           - delivered beats, wraps
//               underflow_err      - sticky underflow indication
// Revision    : 1.0 - initial release
//============================================================================
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = 16,
    parameter int COUNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [COUNT_W-1:0]    rd_count,
    output logic                  underflow_err
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [FIFO_WIDTH-1:0] slot0_q, slot0_d;
    logic [FIFO_WIDTH-1:0] slot1_q, slot1_d;
    logic [COUNT_W-1:0]    rd_count_q;
    logic                  underflow_err_q;

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_committed;

    assign m_valid       = (occ_q != 2'd0);
    assign m_data        = slot0_q;
    assign rd_count      = rd_count_q;
    assign underflow_err = underflow_err_q;

    assign w_pop  = m_valid & m_ready;
    // An in-flight read lands this edge unless the FIFO flagged underflow.
    assign w_push = inflight_q & ~fifo_underflow;

    // Slots committed after this edge: buffered + in-flight - leaving now.
    // A pop implies occ >= 1, so the subtraction never wraps.
    assign w_committed = ({1'b0, occ_q} + {2'b00, inflight_q}) - {2'b00, w_pop};
    assign fifo_rd_en  = ~rst & ~fifo_empty & (w_committed < 3'd2);

    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({w_push, w_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    slot0_d = fifo_data_out;
                end else begin
                    slot1_d = fifo_data_out;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word joins behind the survivor.
                if (occ_q == 2'd1) begin
                    slot0_d = fifo_data_out;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = fifo_data_out;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q           <= 2'd0;
            inflight_q      <= 1'b0;
            slot0_q         <= '0;
            slot1_q         <= '0;
            rd_count_q      <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            if (w_pop) begin
                rd_count_q <= rd_count_q + COUNT_W'(1);
            end
            if (inflight_q & fifo_underflow) begin
                underflow_err_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
//============================================================================
// Module      : tb_fifo_rd_stream
// Description : Self-checking bench for fifo_rd_stream. A behavioural FIFO
//               (queue with one cycle of read latency) feeds the DUT. The
//               expected output stream is every word the FIFO returned
//               without an underflow flag, in order.
// Revision    : 1.0 - initial release
//============================================================================
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_underflow;
    logic [15:0] fifo_data_out;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [15:0] rd_count;
    logic        underflow_err;

    fifo_rd_stream #(.FIFO_WIDTH(16), .COUNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .rd_count       (rd_count),
        .underflow_err  (underflow_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural FIFO and expected stream
    logic [15:0] src_q[$];
    logic [15:0] exp_q[$];
    logic        pend_valid;
    logic [15:0] pend_data;
    logic        pend_uf;
    int          rd_idx;
    int          uf_target;
    int          exp_count;
    logic        last_hold;
    logic [15:0] last_data;

    // Per-cycle history for timing checks
    int          cyc;
    logic        h_rd [0:31];
    logic        h_mv [0:31];
    logic [15:0] h_md [0:31];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic ready);
        logic        rd_s;
        logic        mv_s;
        logic [15:0] md_s;
        m_ready        = ready;
        fifo_empty     = (src_q.size() == 0);
        fifo_data_out  = pend_valid ? pend_data : 16'($urandom);
        fifo_underflow = pend_valid & pend_uf;
        #1;
        rd_s = fifo_rd_en;
        mv_s = m_valid;
        md_s = m_data;
        chk("rd_count", {16'h0, rd_count}, {16'h0, exp_count[15:0]});
        chk("rd_en_while_empty", {31'h0, rd_s & fifo_empty}, 32'h0);
        chk("occ_range", {31'h0, dut.occ_q <= 2'd2}, 32'h1);
        chk("buffer_overflow",
            {31'h0, (dut.occ_q == 2'd2) & dut.inflight_q & ~fifo_underflow & ~(mv_s & ready)},
            32'h0);
        if (last_hold) begin
            chk("hold_valid", {31'h0, mv_s}, 32'h1);
            chk("hold_data", {16'h0, md_s}, {16'h0, last_data});
        end
        if (mv_s && ready) begin
            chk("beat_expected", {31'h0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) begin
                chk("beat_data", {16'h0, md_s}, {16'h0, exp_q.pop_front()});
            end
            exp_count++;
        end
        if (pend_valid && !pend_uf) begin
            exp_q.push_back(pend_data);
        end
        if (rd_s && src_q.size() != 0) begin
            rd_idx++;
            pend_valid = 1'b1;
            pend_data  = src_q.pop_front();
            pend_uf    = (rd_idx == uf_target);
        end else begin
            pend_valid = 1'b0;
            pend_uf    = 1'b0;
        end
        last_hold = mv_s & ~ready;
        last_data = md_s;
        if (cyc < 32) begin
            h_rd[cyc] = rd_s;
            h_mv[cyc] = mv_s;
            h_md[cyc] = md_s;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Reset the DUT and the behavioural FIFO together for one edge.
    task automatic reset_pulse();
        rst            = 1'b1;
        fifo_empty     = 1'b0;
        m_ready        = 1'($urandom);
        fifo_data_out  = pend_valid ? pend_data : 16'hDEAD;
        fifo_underflow = 1'b0;
        #1;
        chk("rst_rd_en", {31'h0, fifo_rd_en}, 32'h0);
        src_q.delete();
        exp_q.delete();
        pend_valid = 1'b0;
        pend_uf    = 1'b0;
        last_hold  = 1'b0;
        exp_count  = 0;
        rd_idx     = 0;
        uf_target  = -1;
        @(posedge clk);
        #1;
        chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
        chk("rst_m_data", {16'h0, m_data}, 32'h0);
        chk("rst_rd_count", {16'h0, rd_count}, 32'h0);
        chk("rst_underflow_err", {31'h0, underflow_err}, 32'h0);
        chk("rst_occ", {30'h0, dut.occ_q}, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1; fifo_empty = 1'b0; fifo_underflow = 1'b0;
        fifo_data_out = 16'h0; m_ready = 1'b0;
        pend_valid = 1'b0; pend_data = 16'h0; pend_uf = 1'b0;
        rd_idx = 0; uf_target = -1; exp_count = 0; last_hold = 1'b0;
        last_data = 16'h0; cyc = 0;

        // 1: reset with a non-empty FIFO, then one idle cycle after release
        reset_pulse();
        cyc = 0;
        cycle(1'b1);
        chk("t1_idle_valid", {31'h0, h_mv[0]}, 32'h0);
        chk("t1_underflow_err", {31'h0, underflow_err}, 32'h0);

        // 2: streaming 8 words with m_ready held high
        for (int i = 1; i <= 8; i++) src_q.push_back(16'(i));
        cyc = 0;
        for (int i = 0; i < 12; i++) cycle(1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("t2_rd_en_run", {31'h0, h_rd[i]}, 32'h1);
            chk("t2_valid_run", {31'h0, h_mv[i+2]}, 32'h1);
            chk("t2_data_run", {16'h0, h_md[i+2]}, i + 1);
        end
        chk("t2_rd_en_stop", {31'h0, h_rd[8]}, 32'h0);
        chk("t2_first_latency", {31'h0, h_mv[1]}, 32'h0);
        chk("t2_valid_stop", {31'h0, h_mv[10]}, 32'h0);
        chk("t2_rd_count", {16'h0, rd_count}, 32'd8);

        // 3: backpressure, then release
        for (int i = 1; i <= 4; i++) src_q.push_back(16'(i));
        for (int i = 0; i < 10; i++) cycle(1'b0);
        m_ready = 1'b0;
        #1;
        chk("t3_occ_full", {30'h0, dut.occ_q}, 32'h2);
        chk("t3_rd_en_blocked", {31'h0, fifo_rd_en}, 32'h0);
        chk("t3_head_valid", {31'h0, m_valid}, 32'h1);
        chk("t3_head_data", {16'h0, m_data}, 32'h1);
        @(posedge clk);
        #1;
        last_hold = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_valid", {31'h0, h_mv[i]}, 32'h1);
            chk("t3_drain_data", {16'h0, h_md[i]}, i + 1);
        end
        chk("t3_drain_end", {31'h0, h_mv[4]}, 32'h0);

        // 4: alternating m_ready with 6 random words
        base = exp_count;
        for (int i = 0; i < 6; i++) src_q.push_back(16'($urandom));
        for (int i = 0; i < 20; i++) cycle(1'((i % 2) == 0));
        chk("t4_beats", exp_count - base, 32'd6);
        chk("t4_model_drained", exp_q.size(), 32'd0);

        // 5: underflow flagged on the 2nd read of this burst
        chk("t5_err_before", {31'h0, underflow_err}, 32'h0);
        base      = exp_count;
        uf_target = rd_idx + 2;
        for (int i = 0; i < 4; i++) src_q.push_back(16'($urandom));
        for (int i = 0; i < 10; i++) cycle(1'b1);
        chk("t5_beats", exp_count - base, 32'd3);
        chk("t5_err_set", {31'h0, underflow_err}, 32'h1);
        for (int i = 0; i < 4; i++) cycle(1'($urandom));
        chk("t5_err_sticky", {31'h0, underflow_err}, 32'h1);

        // Random traffic: random data, random refills, random m_ready
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) != 0 && src_q.size() < 6) src_q.push_back(16'($urandom));
            cycle(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 16; i++) cycle(1'b1);
        chk("rand_drained", exp_q.size() + src_q.size(), 32'd0);

        // 6: reset mid-stream with a buffered beat and a read in flight
        for (int i = 0; i < 6; i++) src_q.push_back(16'h5A00 + 16'(i));
        cycle(1'b0);
        cycle(1'b0);
        chk("t6_pre_inflight", {31'h0, dut.inflight_q}, 32'h1);
        reset_pulse();
        cyc = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        for (int i = 0; i < 3; i++) chk("t6_post_idle", {31'h0, h_mv[i]}, 32'h0);
        base = exp_count;
        for (int i = 0; i < 3; i++) src_q.push_back(16'hC300 + 16'(i));
        cyc = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1);
        chk("t6_fresh_first", {16'h0, h_md[2]}, 32'hC300);
        chk("t6_fresh_beats", exp_count - base, 32'd3);
        chk("t6_err_cleared", {31'h0, underflow_err}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
